sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 4x8 shift-register FIFO.

---
 rtl/sync_fifo_pkg.sv | 29 ++
 rtl/sync_fifo_param_if.sv | 39 +++
 rtl/sync_fifo_ram.sv | 39 +++
 rtl/sync_fifo_param.sv | 138 +++++++++++++
 tb/tb_sync_fifo_param.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Provides the ceiling-log2 helper used to size pointers and the fill-level
// counter, plus the default geometry used by the interface and the top.
package sync_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AF_MARGIN = 1;
  localparam int DEF_AE_MARGIN = 1;

  // Ceiling log2; DEPTH is a power of two so this is the exact pointer width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Pointer width and level/left width (one extra bit to represent DEPTH itself).
  localparam int DEF_AW = clog2(DEF_DEPTH);
  localparam int DEF_LW = DEF_AW + 1;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param.
// master: the side that pushes/pops data; slave: the FIFO itself.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int LW = clog2(DEPTH) + 1;

  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic [LW-1:0]    left;
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_req, wr_data, rd_req, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, left, overflow, underflow
  );

  modport slave (
    input  wr_req, wr_data, rd_req, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, left, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port, one registered read
// port. The array is deliberately not reset; only the read register is.
module sync_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Array write; a same-address read in this cycle still returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock circular-buffer FIFO.
// Holds pointers, fill level, status flags and sticky error flags; storage
// lives in sync_fifo_ram. Optional feature macro: SYNC_FIFO_ERR_EN enables
// the sticky overflow/underflow flags (otherwise they read 0, err_clr inert).
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = DEF_AF_MARGIN,
  parameter int AE_MARGIN = DEF_AE_MARGIN
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_TH_L = LW'(DEPTH - AF_MARGIN);
  localparam logic [LW-1:0] AE_TH_L = LW'(AE_MARGIN);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          rd_valid_r;
  logic          full_s;
  logic          empty_s;
  logic          rd_acc_s;
  logic          wr_acc_s;

  // Status decodes straight off the registered level.
  assign full_s  = (level_r == DEPTH_L);
  assign empty_s = (level_r == {LW{1'b0}});

  // A read frees a slot, so a write into a full FIFO is allowed alongside it.
  // No bypass: a write into an empty FIFO cannot satisfy a same-cycle read.
  assign rd_acc_s = bus.rd_req & ~empty_s;
  assign wr_acc_s = bus.wr_req & (~full_s | rd_acc_s);

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (bus.wr_data),
    .rd_en   (rd_acc_s),
    .rd_addr (rd_ptr_r),
    .rd_data (bus.rd_data)
  );

  // Pointer advance; AW-bit arithmetic wraps naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Fill level: net change of accepted writes and reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= {LW{1'b0}};
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

  // Read-data strobe: one cycle after each accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
    end
  end

  assign bus.rd_valid     = rd_valid_r;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (level_r >= AF_TH_L);
  assign bus.almost_empty = (level_r <= AE_TH_L);
  assign bus.level        = level_r;
  assign bus.left         = DEPTH_L - level_r;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.wr_req & ~wr_acc_s) begin
        overflow_r <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (bus.rd_req & empty_s) begin
        underflow_r <= 1'b1;
      end else if (bus.err_clr) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
`else
  // Error tracking absent: flags stay low; err_clr is masked to zero so it
  // is still read but has no effect.
  assign bus.overflow  = bus.err_clr & 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16, margins 1).
// Stimulus pushes expected read data / read strobes into queues; a monitor
// branch pops and compares at each falling edge.
module tb_sync_fifo_param;

  localparam int W = 8;
  localparam int D = 16;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_MARGIN(1), .AE_MARGIN(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mdl[$];
  logic [7:0] exp_q[$];
  bit         exp_vq[$];
  bit         ovf_m = 1'b0;
  bit         unf_m = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // One clock of stimulus; the bench's own FIFO model decides what is accepted.
  task automatic cycle(input bit wr, input logic [7:0] d, input bit rd,
                       input bit clr = 1'b0, input bit do_rst = 1'b0);
    bit         racc;
    bit         wacc;
    logic [7:0] e;
    e = 8'h00;
    bus.wr_req  = wr;
    bus.wr_data = d;
    bus.rd_req  = rd;
    bus.err_clr = clr;
    rst         = do_rst;
    if (do_rst) begin
      mdl.delete();
      racc  = 1'b0;
      wacc  = 1'b0;
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      racc = rd && (mdl.size() != 0);
      wacc = wr && ((mdl.size() != D) || racc);
      if (ERR_EN) begin
        if (wr && !wacc) ovf_m = 1'b1;
        else if (clr)    ovf_m = 1'b0;
        if (rd && mdl.size() == 0) unf_m = 1'b1;
        else if (clr)              unf_m = 1'b0;
      end
      if (racc) e = mdl.pop_front();
      if (wacc) mdl.push_back(d);
    end
    @(posedge clk);
    #1;
    if (racc) exp_q.push_back(e);
    exp_vq.push_back(racc);
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.err_clr = 1'b0;
    rst         = 1'b0;
    chk("level",        32'(bus.level),        32'(mdl.size()));
    chk("left",         32'(bus.left),         32'(D - mdl.size()));
    chk("full",         32'(bus.full),         32'(mdl.size() == D));
    chk("empty",        32'(bus.empty),        32'(mdl.size() == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(mdl.size() >= D - 1));
    chk("almost_empty", 32'(bus.almost_empty), 32'(mdl.size() <= 1));
    chk("overflow",     32'(bus.overflow),     32'(ovf_m));
    chk("underflow",    32'(bus.underflow),    32'(unf_m));
  endtask

  initial begin
    bus.wr_req  = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_req  = 1'b0;
    bus.err_clr = 1'b0;
    fork
      // Monitor: pop expectations whenever the DUT presents read output.
      begin
        bit v;
        forever begin
          @(negedge clk);
          if (exp_vq.size() != 0) begin
            v = exp_vq.pop_front();
            chk("rd_valid", 32'(bus.rd_valid), 32'(v));
          end
          if (bus.rd_valid === 1'b1) begin
            chk("rd_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
          end
        end
      end
      // Directed stimulus.
      begin
        // 1. reset state, fill 0x01..0x10, drain in order
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_empty",  32'(bus.empty),    32'd1);
        chk("rst_left",   32'(bus.left),     32'd16);
        chk("rst_rdata",  32'(bus.rd_data),  32'h00);
        chk("rst_rvalid", 32'(bus.rd_valid), 32'd0);
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0);
        chk("t1_full",  32'(bus.full),  32'd1);
        chk("t1_level", 32'(bus.level), 32'd16);
        chk("t1_left",  32'(bus.left),  32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t1_last", 32'(bus.rd_data), 32'h10);
        chk("t1_empty", 32'(bus.empty), 32'd1);
        // 2. pointer wrap
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t2_last", 32'(bus.rd_data), 32'h4B);
        // 3. full with simultaneous write and read
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b1);
        chk("t3_level", 32'(bus.level), 32'd16);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t3_aa_last", 32'(bus.rd_data), 32'hAA);
        // 4. empty with simultaneous write and read (no bypass)
        cycle(1'b1, 8'h55, 1'b1);
        chk("t4_level", 32'(bus.level), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t4_data", 32'(bus.rd_data), 32'h55);
        // 5. overflow, clear, underflow
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        chk("t5_ovf_set", 32'(bus.overflow), 32'(ERR_EN));
        chk("t5_level", 32'(bus.level), 32'd16);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_ovf_clr", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t5_last", 32'(bus.rd_data), 32'h8F);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t5_unf_set", 32'(bus.underflow), 32'(ERR_EN));
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        chk("t5_unf_prio", 32'(bus.underflow), 32'(ERR_EN));
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_unf_clr", 32'(bus.underflow), 32'd0);
        // 6. reset mid-operation with level 7
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(1'b1, 8'hC7, 1'b1);
        chk("t6_level7", 32'(bus.level), 32'd7);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t6_level", 32'(bus.level),    32'd0);
        chk("t6_empty", 32'(bus.empty),    32'd1);
        chk("t6_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_rdata", 32'(bus.rd_data),  32'h00);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("drain", 32'(exp_q.size()), 32'd0);
      end
      // Watchdog bound.
      begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got no completion, required completion by 200000");
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
